// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, load/store width codes, memory-stage
// state encoding and the store-lane / alignment helpers.
package core_pkg;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;

   // Unsigned load widths are illegal encodings for stores.
   function automatic logic access_misaligned(input logic [2:0] funct3,
                                              input logic [1:0] off,
                                              input logic       is_store);
      logic legal;
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (!is_store && ((funct3 == F3_BU) || (funct3 == F3_HU)));
      return !legal || ((funct3[1:0] == 2'b01) && off[0]) ||
             ((funct3[1:0] == 2'b10) && (off != 2'b00));
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                           input logic [1:0] off);
      case (funct3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                               input logic [31:0] data);
      case (funct3[1:0])
         2'b00:   return {4{data[7:0]}};
         2'b01:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_format.sv
// Load data formatter: selects byte/half from a fetched word and extends it
// according to funct3.
module mem_load_format
   import core_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] wdata32
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (funct3)
         F3_B:    wdata32 = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   wdata32 = {24'd0, byte_sel};
         F3_H:    wdata32 = {{16{half_sel[15]}}, half_sel};
         F3_HU:   wdata32 = {16'd0, half_sel};
         default: wdata32 = rdata;
      endcase
   end

endmodule

// File: rtl/stage_memory.sv
// Memory/writeback stage: issues loads/stores on the dmem valid/ready bus,
// stalls execute while an access is outstanding, and registers the writeback.
//
// state | meaning
// IDLE  | accepting from execute; ALU results pass straight to writeback
// REQ   | request held on the bus until dmem_req_ready
// RESP  | load issued, waiting for dmem_rsp_valid
module stage_memory
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_alu_result,
   input  logic [XLEN-1:0] ex_store_data,
   input  logic [4:0]      ex_rd,
   input  logic [2:0]      ex_funct3,
   input  logic            ex_wr_enable,
   input  logic            ex_mem_to_reg,
   input  logic            ex_mem_write,
   output logic            mem_stall,
   output logic            mem_misaligned,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic [XLEN-1:0] dmem_addr,
   output logic            dmem_we,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [4:0]      wb_wr_addr,
   output logic [XLEN-1:0] wb_wr_data,
   output logic            wb_wr_enable
);

   mem_state_t      state, state_next;
   logic            mem_op, misaligned;
   logic            alu_done, drop, capture, req_done, rsp_done;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic            wr_en_q;
   logic [XLEN-1:0] load_data;

   assign mem_op     = ex_mem_to_reg | ex_mem_write;
   assign misaligned = access_misaligned(ex_funct3, ex_alu_result[1:0], ex_mem_write);

   mem_load_format u_load_format (
      .rdata   (dmem_rdata),
      .offset  (off_q),
      .funct3  (f3_q),
      .wdata32 (load_data)
   );

   always_comb begin
      state_next = state;
      mem_stall  = 1'b0;
      alu_done   = 1'b0;
      drop       = 1'b0;
      capture    = 1'b0;
      req_done   = 1'b0;
      rsp_done   = 1'b0;
      case (state)
         IDLE: begin
            if (ex_valid) begin
               if (!mem_op) begin
                  alu_done = 1'b1;
               end else if (misaligned) begin
                  drop = 1'b1;
               end else begin
                  capture    = 1'b1;
                  mem_stall  = 1'b1;
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            if (dmem_req_ready) begin
               req_done   = 1'b1;
               mem_stall  = !dmem_we;
               state_next = dmem_we ? IDLE : RESP;
            end else begin
               mem_stall = 1'b1;
            end
         end
         RESP: begin
            if (dmem_rsp_valid) begin
               rsp_done   = 1'b1;
               state_next = IDLE;
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         dmem_req_valid <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_be        <= 4'd0;
         dmem_addr      <= '0;
         dmem_wdata     <= '0;
         wb_wr_addr     <= 5'd0;
         wb_wr_data     <= '0;
         wb_wr_enable   <= 1'b0;
         mem_misaligned <= 1'b0;
         off_q          <= 2'd0;
         f3_q           <= 3'd0;
         rd_q           <= 5'd0;
         wr_en_q        <= 1'b0;
      end else begin
         state          <= state_next;
         wb_wr_enable   <= 1'b0;
         mem_misaligned <= drop;
         if (alu_done) begin
            wb_wr_enable <= ex_wr_enable && (ex_rd != 5'd0);
            wb_wr_addr   <= ex_rd;
            wb_wr_data   <= ex_alu_result;
         end
         if (capture) begin
            dmem_req_valid <= 1'b1;
            dmem_we        <= ex_mem_write;
            dmem_addr      <= {ex_alu_result[XLEN-1:2], 2'b00};
            dmem_be        <= ex_mem_write ? store_be(ex_funct3, ex_alu_result[1:0]) : 4'd0;
            dmem_wdata     <= ex_mem_write ? store_lanes(ex_funct3, ex_store_data) : '0;
            off_q          <= ex_alu_result[1:0];
            f3_q           <= ex_funct3;
            rd_q           <= ex_rd;
            wr_en_q        <= ex_wr_enable;
         end
         if (req_done) begin
            dmem_req_valid <= 1'b0;
         end
         if (rsp_done) begin
            wb_wr_enable <= wr_en_q && (rd_q != 5'd0);
            wb_wr_addr   <= rd_q;
            wb_wr_data   <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed scenarios plus randomized
// operations checked against an arithmetic reference of the load/store rules.
module tb_stage_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_wr_enable, ex_mem_to_reg, ex_mem_write;
   logic        mem_stall, mem_misaligned;
   logic        dmem_req_valid, dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data;
   logic        wb_wr_enable;

   int n_cmp = 0;
   int n_err = 0;

   int          obs_wb_cnt, obs_mis_cnt, obs_stall, obs_req_cycles;
   bit          obs_changed, obs_timeout;
   logic [4:0]  obs_wb_addr;
   logic [31:0] obs_wb_data, obs_req_addr, obs_req_wdata;
   logic        obs_req_we;
   logic [3:0]  obs_req_be;

   always #5 clk = ~clk;

   stage_memory #(.XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_alu_result  (ex_alu_result),
      .ex_store_data  (ex_store_data),
      .ex_rd          (ex_rd),
      .ex_funct3      (ex_funct3),
      .ex_wr_enable   (ex_wr_enable),
      .ex_mem_to_reg  (ex_mem_to_reg),
      .ex_mem_write   (ex_mem_write),
      .mem_stall      (mem_stall),
      .mem_misaligned (mem_misaligned),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_addr      (dmem_addr),
      .dmem_we        (dmem_we),
      .dmem_be        (dmem_be),
      .dmem_wdata     (dmem_wdata),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rdata     (dmem_rdata),
      .wb_wr_addr     (wb_wr_addr),
      .wb_wr_data     (wb_wr_data),
      .wb_wr_enable   (wb_wr_enable)
   );

   // ---------------- reference model ----------------
   function automatic bit ref_misaligned(bit is_store, logic [2:0] f3, logic [31:0] addr);
      int size;
      bit legal;
      legal = is_store ? (f3 == 0 || f3 == 1 || f3 == 2)
                       : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      if (!legal) return 1'b1;
      size = 1 << f3[1:0];
      return (addr % size) != 0;
   endfunction

   function automatic logic [31:0] ref_load(logic [31:0] rdata, logic [31:0] addr, logic [2:0] f3);
      logic [31:0] w, v;
      w = rdata >> ((addr % 4) * 8);
      case (f3)
         3'd0: begin v = w % 256;   return (v >= 128)   ? v - 32'd256   : v; end
         3'd4: return w % 256;
         3'd1: begin v = w % 65536; return (v >= 32768) ? v - 32'd65536 : v; end
         3'd5: return w % 65536;
         default: return rdata;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(logic [2:0] f3, logic [31:0] addr);
      int n;
      n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 3 : 15;
      return 4'((n << (addr % 4)) % 16);
   endfunction

   function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] d);
      if (f3[1:0] == 2'd0) return (d % 256) * 32'h0101_0101;
      if (f3[1:0] == 2'd1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   // ---------------- stimulus / observation ----------------
   task automatic observe();
      if (dmem_req_valid) begin
         if (obs_req_cycles == 0) begin
            obs_req_addr  = dmem_addr;
            obs_req_we    = dmem_we;
            obs_req_be    = dmem_be;
            obs_req_wdata = dmem_wdata;
         end else if (dmem_addr !== obs_req_addr || dmem_we !== obs_req_we ||
                      dmem_be !== obs_req_be || dmem_wdata !== obs_req_wdata) begin
            obs_changed = 1'b1;
         end
         obs_req_cycles++;
      end
      if (wb_wr_enable) begin
         obs_wb_cnt++;
         obs_wb_addr = wb_wr_addr;
         obs_wb_data = wb_wr_data;
      end
      if (mem_misaligned) obs_mis_cnt++;
   endtask

   task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input bit wr_en, input int rdly,
                         input int sdly, input logic [31:0] rdata, input bit noise);
      int  req_wait, resp_cnt, cyc;
      bit  resp_phase, advanced, hs, taken, rv;
      obs_wb_cnt = 0; obs_mis_cnt = 0; obs_stall = 0; obs_req_cycles = 0;
      obs_changed = 0; obs_timeout = 0; obs_wb_addr = '0; obs_wb_data = '0;
      obs_req_addr = '0; obs_req_we = 0; obs_req_be = '0; obs_req_wdata = '0;
      req_wait = 0; resp_cnt = 0; cyc = 0; resp_phase = 0; advanced = 0;
      ex_valid = 1; ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd;
      ex_funct3 = f3; ex_wr_enable = wr_en; ex_mem_to_reg = ld; ex_mem_write = st;
      dmem_rdata = rdata;
      while (!advanced && cyc < 60) begin
         dmem_req_ready = dmem_req_valid ? (req_wait >= rdly) : (noise && $urandom_range(0, 1) == 1);
         dmem_rsp_valid = resp_phase ? (resp_cnt >= sdly) : (noise && $urandom_range(0, 1) == 1);
         @(negedge clk);
         observe();
         rv    = dmem_req_valid;
         hs    = dmem_req_valid && dmem_req_ready;
         taken = resp_phase && dmem_rsp_valid;
         if (mem_stall) obs_stall++; else advanced = 1;
         if (taken) resp_phase = 0; else if (resp_phase) resp_cnt++;
         if (hs && ld) begin resp_phase = 1; resp_cnt = 0; end
         else if (rv && !hs) req_wait++;
         cyc++;
         @(posedge clk); #1;
      end
      ex_valid = 0; ex_mem_to_reg = 0; ex_mem_write = 0;
      ex_alu_result = $urandom(); ex_rd = 5'($urandom());
      if (!advanced) begin
         obs_timeout = 1;
         rst = 1; @(posedge clk); #1; rst = 0;
      end
      repeat (3) begin
         dmem_req_ready = noise && $urandom_range(0, 1) == 1;
         dmem_rsp_valid = noise && $urandom_range(0, 1) == 1;
         @(negedge clk);
         observe();
         @(posedge clk); #1;
      end
      dmem_req_ready = 0; dmem_rsp_valid = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1; ex_valid = 0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
      ex_funct3 = '0; ex_wr_enable = 0; ex_mem_to_reg = 0; ex_mem_write = 0;
      dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_wr_addr,
           wb_wr_data, wb_wr_enable, mem_misaligned, mem_stall} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got req=%b we=%b be=%h addr=%h wd=%h wa=%0d wdat=%h wen=%b mis=%b stall=%b want all 0",
                  dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_wr_addr,
                  wb_wr_data, wb_wr_enable, mem_misaligned, mem_stall);
      end
      @(posedge clk); #1; rst = 0;
   endtask

   task automatic test_alu();
      run_op(0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 32'h0, 0);
      n_cmp++; if (obs_wb_cnt !== 1) begin n_err++; $display("FAIL alu_wb_count got %0d want 1", obs_wb_cnt); end
      n_cmp++; if (obs_wb_addr !== 5'd5 || obs_wb_data !== 32'h1234) begin n_err++;
         $display("FAIL alu_wb_value got %0d/%h want 5/00001234", obs_wb_addr, obs_wb_data); end
      n_cmp++; if (obs_stall !== 0 || obs_req_cycles !== 0) begin n_err++;
         $display("FAIL alu_no_stall got stall=%0d req=%0d want 0/0", obs_stall, obs_req_cycles); end
   endtask

   task automatic test_load_lb();
      run_op(1, 0, 3'd0, 32'h103, 32'h0, 5'd9, 1, 0, 1, 32'h80FF_0011, 0);
      n_cmp++; if (obs_wb_cnt !== 1 || obs_wb_data !== 32'hFFFF_FF80 || obs_wb_addr !== 5'd9) begin n_err++;
         $display("FAIL lb_wb got cnt=%0d %0d/%h want 1 9/ffffff80", obs_wb_cnt, obs_wb_addr, obs_wb_data); end
      n_cmp++; if (obs_stall !== 3) begin n_err++; $display("FAIL lb_stall_cycles got %0d want 3", obs_stall); end
      n_cmp++; if (obs_req_addr !== 32'h100 || obs_req_we !== 0 || obs_req_cycles !== 1) begin n_err++;
         $display("FAIL lb_request got addr=%h we=%b cyc=%0d want 100/0/1", obs_req_addr, obs_req_we, obs_req_cycles); end
   endtask

   task automatic test_load_lhu_lw();
      run_op(1, 0, 3'd5, 32'h102, 32'h0, 5'd10, 1, 1, 0, 32'hBEEF_1234, 0);
      n_cmp++; if (obs_wb_cnt !== 1 || obs_wb_data !== 32'h0000_BEEF) begin n_err++;
         $display("FAIL lhu_wb got cnt=%0d data=%h want 1 0000beef", obs_wb_cnt, obs_wb_data); end
      run_op(1, 0, 3'd2, 32'h200, 32'h0, 5'd11, 1, 0, 2, 32'hBEEF_1234, 0);
      n_cmp++; if (obs_wb_cnt !== 1 || obs_wb_data !== 32'hBEEF_1234 || obs_wb_addr !== 5'd11) begin n_err++;
         $display("FAIL lw_wb got cnt=%0d %0d/%h want 1 11/beef1234", obs_wb_cnt, obs_wb_addr, obs_wb_data); end
      n_cmp++; if (obs_stall !== 4) begin n_err++; $display("FAIL lw_stall_cycles got %0d want 4", obs_stall); end
   endtask

   task automatic test_store_delay();
      run_op(0, 1, 3'd0, 32'h41, 32'hAB, 5'd3, 0, 3, 0, 32'h0, 0);
      n_cmp++; if (obs_req_be !== 4'b0010 || obs_req_wdata !== 32'hABAB_ABAB || obs_req_we !== 1) begin n_err++;
         $display("FAIL sb_lanes got be=%b wdata=%h we=%b want 0010 abababab 1", obs_req_be, obs_req_wdata, obs_req_we); end
      n_cmp++; if (obs_req_addr !== 32'h40 || obs_req_cycles !== 4 || obs_changed) begin n_err++;
         $display("FAIL sb_request got addr=%h cyc=%0d changed=%b want 40/4/0", obs_req_addr, obs_req_cycles, obs_changed); end
      n_cmp++; if (obs_wb_cnt !== 0 || obs_stall !== 4) begin n_err++;
         $display("FAIL sb_wb_stall got wb=%0d stall=%0d want 0/4", obs_wb_cnt, obs_stall); end
   endtask

   task automatic test_misaligned();
      run_op(1, 0, 3'd2, 32'h102, 32'h0, 5'd4, 1, 0, 0, 32'h5555_5555, 0);
      n_cmp++; if (obs_req_cycles !== 0 || obs_mis_cnt !== 1 || obs_wb_cnt !== 0 || obs_stall !== 0) begin n_err++;
         $display("FAIL mis_lw got req=%0d mis=%0d wb=%0d stall=%0d want 0/1/0/0", obs_req_cycles, obs_mis_cnt, obs_wb_cnt, obs_stall); end
      run_op(0, 1, 3'd1, 32'h1, 32'hCAFE, 5'd0, 0, 0, 0, 32'h0, 0);
      n_cmp++; if (obs_req_cycles !== 0 || obs_mis_cnt !== 1 || obs_wb_cnt !== 0 || obs_stall !== 0) begin n_err++;
         $display("FAIL mis_sh got req=%0d mis=%0d wb=%0d stall=%0d want 0/1/0/0", obs_req_cycles, obs_mis_cnt, obs_wb_cnt, obs_stall); end
   endtask

   task automatic test_reset_in_resp();
      int wb_seen, req_seen;
      ex_valid = 1; ex_alu_result = 32'h300; ex_rd = 5'd7; ex_funct3 = 3'd2;
      ex_wr_enable = 1; ex_mem_to_reg = 1; ex_mem_write = 0; dmem_req_ready = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      dmem_req_ready = 0;
      @(negedge clk);
      n_cmp++; if (mem_stall !== 1 || dmem_req_valid !== 0) begin n_err++;
         $display("FAIL resp_wait got stall=%b req=%b want 1/0", mem_stall, dmem_req_valid); end
      rst = 1;
      @(posedge clk); #1;
      rst = 0; ex_valid = 0; ex_mem_to_reg = 0;
      @(negedge clk);
      n_cmp++;
      if ({dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_wr_addr,
           wb_wr_data, wb_wr_enable, mem_misaligned, mem_stall} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_access got req=%b we=%b addr=%h wen=%b stall=%b want all 0",
                  dmem_req_valid, dmem_we, dmem_addr, wb_wr_enable, mem_stall);
      end
      dmem_rsp_valid = 1; dmem_rdata = 32'h1234_5678;
      wb_seen = 0; req_seen = 0;
      repeat (3) begin
         @(posedge clk); #1; dmem_rsp_valid = 0;
         @(negedge clk);
         if (wb_wr_enable) wb_seen++;
         if (dmem_req_valid) req_seen++;
      end
      n_cmp++; if (wb_seen !== 0 || req_seen !== 0) begin n_err++;
         $display("FAIL late_rsp got wb=%0d req=%0d want 0/0", wb_seen, req_seen); end
      @(posedge clk); #1;
      run_op(1, 0, 3'd2, 32'h400, 32'h0, 5'd0, 1, 0, 0, 32'hDEAD_BEEF, 0);
      n_cmp++; if (obs_wb_cnt !== 0 || obs_req_cycles !== 1 || obs_stall !== 2) begin n_err++;
         $display("FAIL x0_load got wb=%0d req=%0d stall=%0d want 0/1/2", obs_wb_cnt, obs_req_cycles, obs_stall); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         int          kind, rdly, sdly, exp_stall;
         bit          ld, st, mis, exp_req, exp_wb, wr_en;
         logic [2:0]  f3;
         logic [31:0] addr, sdata, rdata, exp_data;
         logic [4:0]  rd;
         kind  = $urandom_range(0, 2);
         ld    = (kind == 1);
         st    = (kind == 2);
         f3    = 3'($urandom_range(0, 7));
         addr  = $urandom();
         sdata = $urandom();
         rdata = $urandom();
         rd    = 5'($urandom());
         wr_en = ld ? 1'b1 : st ? 1'b0 : ($urandom_range(0, 3) != 0);
         rdly  = $urandom_range(0, 3);
         sdly  = $urandom_range(0, 3);
         mis       = (ld || st) && ref_misaligned(st, f3, addr);
         exp_req   = (ld || st) && !mis;
         exp_wb    = ((kind == 0) || (ld && !mis)) && wr_en && (rd != 0);
         exp_data  = ld ? ref_load(rdata, addr, f3) : addr;
         exp_stall = !exp_req ? 0 : st ? 1 + rdly : 2 + rdly + sdly;
         run_op(ld, st, f3, addr, sdata, rd, wr_en, rdly, sdly, rdata, 1);
         n_cmp++; if (obs_timeout) begin n_err++; $display("FAIL rnd%0d_timeout got timeout want completion", i); end
         n_cmp++; if (obs_wb_cnt !== int'(exp_wb)) begin n_err++;
            $display("FAIL rnd%0d_wb_count kind=%0d f3=%0d addr=%h got %0d want %0d", i, kind, f3, addr, obs_wb_cnt, exp_wb); end
         if (exp_wb) begin
            n_cmp++; if (obs_wb_addr !== rd || obs_wb_data !== exp_data) begin n_err++;
               $display("FAIL rnd%0d_wb_value kind=%0d f3=%0d addr=%h got %0d/%h want %0d/%h",
                        i, kind, f3, addr, obs_wb_addr, obs_wb_data, rd, exp_data); end
         end
         n_cmp++; if (obs_stall !== exp_stall || obs_mis_cnt !== int'(mis)) begin n_err++;
            $display("FAIL rnd%0d_stall_mis got stall=%0d mis=%0d want %0d/%0d", i, obs_stall, obs_mis_cnt, exp_stall, mis); end
         n_cmp++; if ((obs_req_cycles != 0) !== exp_req || obs_changed) begin n_err++;
            $display("FAIL rnd%0d_req got cyc=%0d changed=%b want req=%b", i, obs_req_cycles, obs_changed, exp_req); end
         if (exp_req) begin
            n_cmp++; if (obs_req_addr !== {addr[31:2], 2'b00} || obs_req_we !== st) begin n_err++;
               $display("FAIL rnd%0d_req_fields got addr=%h we=%b want %h/%b", i, obs_req_addr, obs_req_we, {addr[31:2], 2'b00}, st); end
         end
         if (exp_req && st) begin
            n_cmp++; if (obs_req_be !== ref_be(f3, addr) || obs_req_wdata !== ref_wdata(f3, sdata)) begin n_err++;
               $display("FAIL rnd%0d_store_lanes got be=%b wd=%h want %b/%h", i, obs_req_be, obs_req_wdata,
                        ref_be(f3, addr), ref_wdata(f3, sdata)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_lb();
      test_load_lhu_lw();
      test_store_delay();
      test_misaligned();
      test_reset_in_resp();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Memory/writeback stage of the in-order RV32I core, placed between execute and the decode stage's register file.
- Performs loads and stores over a valid/ready data-memory interface and stalls upstream while an access is outstanding.
- Formats load data (byte/half/word, sign/zero extension) and produces the registered writeback triple (wb_wr_addr, wb_wr_data, wb_wr_enable) consumed by decode's register file.
- Non-memory ALU results pass through with one cycle of latency.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute stage presents an instruction
- ex_alu_result  in  32  ALU result, or effective address for load/store
- ex_store_data  in  32  rs2 data for stores
- ex_rd  in  5  destination register
- ex_funct3  in  3  load/store width and sign encoding
- ex_wr_enable  in  1  instruction writes rd
- ex_mem_to_reg  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- mem_stall  out  1  upstream must hold all ex_* inputs stable (combinational)
- mem_misaligned  out  1  one-cycle pulse: misaligned or illegal-width access dropped
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_we  out  1  1 = store
- dmem_be  out  4  byte enables for stores
- dmem_wdata  out  32  store data, lane-replicated
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  32  load data word
- wb_wr_addr  out  5  register file write address
- wb_wr_data  out  32  register file write data
- wb_wr_enable  out  1  register file write strobe

Behaviour:
- Reset: state IDLE. All registered outputs are 0: dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_wr_addr, wb_wr_data, wb_wr_enable, mem_misaligned.
- FSM states: IDLE, REQ, RESP.
- IDLE with ex_valid and neither load nor store: next cycle wb_wr_enable = ex_wr_enable and (ex_rd != 0), wb_wr_addr = ex_rd, wb_wr_data = ex_alu_result. Latency is 1 cycle; no stall.
- IDLE with ex_valid and a load or store:
  - Aligned: capture the request, go to REQ, assert mem_stall this cycle.
  - Misaligned: see the alignment rule below.
- REQ:
  - dmem_req_valid = 1 and all request fields stay constant until dmem_req_ready.
  - Store handshake: return to IDLE. No writeback; the write is posted.
  - Load handshake: go to RESP. dmem_req_valid drops the cycle after the handshake.
- RESP:
  - Wait for dmem_rsp_valid, then register the formatted data into the wb_* outputs next cycle and return to IDLE.
  - wb_wr_enable follows the same rd != 0 rule as the ALU path.
- mem_stall = (IDLE & ex_valid & mem_op & aligned) | (REQ & !(dmem_req_ready & dmem_we)) | (RESP & !dmem_rsp_valid).
- mem_stall is deasserted in the completion cycle, so upstream advances exactly once per instruction.
- wb_wr_enable is a single-cycle pulse per instruction. It is 0 in every cycle with no completion, including all stall cycles.
- Alignment: an access is misaligned when:
  - funct3[1:0] = 01 and addr[0] = 1, or
  - funct3[1:0] = 10 and addr[1:0] != 0, or
  - funct3 is not in {000, 001, 010, 100, 101} for loads or {000, 001, 010} for stores.
- Misaligned access: no bus request and no writeback; mem_misaligned pulses 1 the next cycle; no stall.
- Store lanes:
  - SB: be = 0001 << off, wdata = {4{data[7:0]}}.
  - SH: be = 0011 << off, wdata = {2{data[15:0]}}.
  - SW: be = 1111, wdata = data.
- Load format:
  - Select the byte or half using addr[1:0] held from capture.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word.
- dmem_rsp_valid outside RESP is ignored.
- dmem_req_ready outside REQ is ignored.
- Reset mid-access returns to IDLE and drops dmem_req_valid. A late response is discarded.

Decomposition:
- core_pkg holds:
  - the opcode localparams (R_TYPE, I_TYPE, LOAD, STORE, ...),
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU,
  - the mem_state_t enum {IDLE, REQ, RESP}.
- One combinational sub-module, mem_load_format, takes (rdata, offset, funct3) and returns wdata32. It is shared with future cache work.

Test Plan:
- ALU pass-through: ex_valid, rd=5, alu_result=0x1234, wr_enable=1 -> next cycle wb_wr_enable=1, addr=5, data=0x1234; mem_stall=0 throughout.
- LB with sign extension: addr=0x103, rdata=0x80FF_0011, ready on the first REQ cycle, rsp 2 cycles later -> wb_wr_data=0xFFFF_FF80, rd written once; mem_stall high until the rsp cycle.
- LHU and LW: addr=0x102, rdata=0xBEEF_1234 -> 0x0000_BEEF. Then LW addr=0x200 -> full word.
- Store with ready delayed 3 cycles: SB addr=0x41, data=0xAB -> dmem_be=0010, wdata=0xABABABAB, request fields stable across wait cycles, wb_wr_enable stays 0.
- Misaligned accesses: LW addr=0x102 and SH addr=0x1 -> no dmem_req_valid, mem_misaligned pulse, no writeback, no stall.
- Reset in RESP, then a late dmem_rsp_valid -> state IDLE, all outputs 0, no write; x0 load (rd=0) -> wb_wr_enable=0.
